// File: rtl/multdiv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// multdiv_seq_ctrl
//   Sequencer for the iterative multiply/divide datapath. A single-cycle
//   ctrl_MULT or ctrl_DIV pulse starts an operation: one LOAD cycle, ITERS
//   RUN cycles that each pulse step, then one DONE cycle that pulses
//   resultRDY together with the exception flag.
//
//   Optional feature macro: MULTDIV_EARLY_EXIT_EN
//     When defined, the early_exit input is present. In RUN, early_exit ends
//     the operation on that step.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   clr        : synchronous active-high reset
//   ctrl_MULT  : start multiply (1-cycle pulse)
//   ctrl_DIV   : start divide (1-cycle pulse)
//   div_zero   : divisor==0 flag from the datapath, sampled in LOAD
//   ovf_in     : overflow flag from the datapath, sampled on the final step
//   early_exit : (MULTDIV_EARLY_EXIT_EN only) terminate RUN this cycle
//   load       : load operands into the datapath
//   step       : advance the datapath one iteration
//   op_div     : latched operation, 1=divide 0=multiply
//   count      : current iteration index
//   busy       : operation in flight (LOAD or RUN)
//   resultRDY  : 1-cycle pulse, result valid
//   exception  : exception flag, meaningful only while resultRDY=1
// ----------------------------------------------------------------------------
module multdiv_seq_ctrl #(
  parameter int unsigned ITERS = 32,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ctrl_MULT,
  input  logic          ctrl_DIV,
  input  logic          div_zero,
  input  logic          ovf_in,
`ifdef MULTDIV_EARLY_EXIT_EN
  input  logic          early_exit,
`endif
  output logic          load,
  output logic          step,
  output logic          op_div,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          resultRDY,
  output logic          exception
);

  localparam logic [CW-1:0] LAST_IDX = CW'(ITERS - 1);

  // Elaboration-time sanity on the configuration.
  if (ITERS < 2) begin : g_iters_min
    $error("multdiv_seq_ctrl: ITERS must be at least 2");
  end
  if (ITERS > (2 ** CW)) begin : g_iters_fit
    $error("multdiv_seq_ctrl: ITERS must not exceed 2**CW");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          start_c;
  logic          last_c;
  logic          finish_c;

  logic          load_nxt;
  logic          step_nxt;
  logic          busy_nxt;
  logic          rdy_nxt;
  logic          op_div_nxt;
  logic          exc_nxt;
  logic [CW-1:0] count_nxt;

  // A start needs exactly one of the two request lines; both together is noise.
  assign start_c = ctrl_MULT ^ ctrl_DIV;
  assign last_c  = (count == LAST_IDX);

`ifdef MULTDIV_EARLY_EXIT_EN
  assign finish_c = last_c | early_exit;
`else
  assign finish_c = last_c;
`endif

  // State register plus the registered copies of every output.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      load      <= 1'b0;
      step      <= 1'b0;
      busy      <= 1'b0;
      resultRDY <= 1'b0;
      op_div    <= 1'b0;
      exception <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      load      <= load_nxt;
      step      <= step_nxt;
      busy      <= busy_nxt;
      resultRDY <= rdy_nxt;
      op_div    <= op_div_nxt;
      exception <= exc_nxt;
      count     <= count_nxt;
    end
  end

  // Next-state logic. A new start from any state restarts at LOAD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_c) state_nxt = LOAD;
      end
      LOAD: begin
        if (start_c)                 state_nxt = LOAD;
        else if (op_div && div_zero) state_nxt = DONE;
        else                         state_nxt = RUN;
      end
      RUN: begin
        if (start_c)       state_nxt = LOAD;
        else if (finish_c) state_nxt = DONE;
      end
      DONE: begin
        if (start_c) state_nxt = LOAD;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: strobes are decoded from the upcoming state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    load_nxt   = (state_nxt == LOAD);
    step_nxt   = (state_nxt == RUN);
    busy_nxt   = (state_nxt == LOAD) || (state_nxt == RUN);
    rdy_nxt    = (state_nxt == DONE);
    op_div_nxt = op_div;
    exc_nxt    = exception;
    count_nxt  = count;

    if (start_c) begin
      // Abort anything in flight and latch the new operation.
      op_div_nxt = ctrl_DIV;
      exc_nxt    = 1'b0;
      count_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          exc_nxt = 1'b0;
        end
        LOAD: begin
          count_nxt = '0;
          exc_nxt   = op_div && div_zero;
        end
        RUN: begin
          if (finish_c) begin
            // Count holds on the final step so DONE reports the last index.
            exc_nxt = op_div ? 1'b0 : ovf_in;
          end else begin
            count_nxt = CW'(count + 1'b1);
            exc_nxt   = 1'b0;
          end
        end
        DONE: begin
          exc_nxt = 1'b0;
        end
        default: begin
          exc_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multdiv_seq_ctrl
//   Self-checking bench for multdiv_seq_ctrl (ITERS=32, CW=5). Expected
//   results are queued when an operation is started and compared when the
//   sequencer raises resultRDY.
// ----------------------------------------------------------------------------
module tb_multdiv_seq_ctrl;

  localparam int unsigned ITERS = 32;
  localparam int unsigned CW    = 5;

  logic          clk;
  logic          clr;
  logic          ctrl_MULT;
  logic          ctrl_DIV;
  logic          div_zero;
  logic          ovf_in;
`ifdef MULTDIV_EARLY_EXIT_EN
  logic          early_exit;
`endif
  logic          load;
  logic          step;
  logic          op_div;
  logic [CW-1:0] count;
  logic          busy;
  logic          resultRDY;
  logic          exception;

  typedef struct {
    logic op_div;
    logic exc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   passed;
  int   total;

  multdiv_seq_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
    .clk       (clk),
    .clr       (clr),
    .ctrl_MULT (ctrl_MULT),
    .ctrl_DIV  (ctrl_DIV),
    .div_zero  (div_zero),
    .ovf_in    (ovf_in),
`ifdef MULTDIV_EARLY_EXIT_EN
    .early_exit(early_exit),
`endif
    .load      (load),
    .step      (step),
    .op_div    (op_div),
    .count     (count),
    .busy      (busy),
    .resultRDY (resultRDY),
    .exception (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start request; returns in the cycle after the sampling edge.
  task automatic start_op(input logic m, input logic d);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic test_reset();
    clr       = 1'b1;
    ctrl_MULT = 1'b1;
    tick();
    total++; if (step !== 1'b0) $display("FAIL reset_step1 got=%b exp=0", step); else passed++;
    tick();
    clr       = 1'b0;
    ctrl_MULT = 1'b0;
    total++; if (load !== 1'b0) $display("FAIL reset_load got=%b exp=0", load); else passed++;
    total++; if (step !== 1'b0) $display("FAIL reset_step got=%b exp=0", step); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (resultRDY !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", resultRDY); else passed++;
    total++; if (exception !== 1'b0) $display("FAIL reset_exc got=%b exp=0", exception); else passed++;
    total++; if (op_div !== 1'b0) $display("FAIL reset_opdiv got=%b exp=0", op_div); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else passed++;
  endtask

  // Full-length operation; ovf_in is pulsed only in the RUN cycle whose count equals ovf_at.
  task automatic test_full_op(input logic is_div, input int ovf_at, input logic ovf_const);
    exp_t e;
    e.op_div = is_div;
    e.exc    = (!is_div) && (ovf_at == int'(ITERS - 1) || ovf_const);
    start_op(!is_div, is_div);
    sb.push_back(e);
    total++; if (load !== 1'b1) $display("FAIL op_load got=%b exp=1", load); else passed++;
    total++; if (step !== 1'b0) $display("FAIL op_load_step got=%b exp=0", step); else passed++;
    total++; if (count !== '0) $display("FAIL op_load_count got=%0d exp=0", count); else passed++;
    total++; if (op_div !== is_div) $display("FAIL op_opdiv got=%b exp=%b", op_div, is_div); else passed++;
    tick();
    for (int k = 0; k < int'(ITERS); k++) begin
      total++;
      if (step !== 1'b1 || busy !== 1'b1 || resultRDY !== 1'b0 || count !== CW'(k))
        $display("FAIL op_run k=%0d step=%b busy=%b rdy=%b count=%0d exp step=1 busy=1 rdy=0 count=%0d",
                 k, step, busy, resultRDY, count, k);
      else passed++;
      ovf_in = ovf_const || (k == ovf_at);
      tick();
    end
    ovf_in = 1'b0;
    total++; if (resultRDY !== 1'b1) $display("FAIL op_rdy got=%b exp=1", resultRDY); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL op_done_busy got=%b exp=0", busy); else passed++;
    total++; if (count !== CW'(ITERS - 1)) $display("FAIL op_done_count got=%0d exp=%0d", count, ITERS - 1); else passed++;
    if (resultRDY === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      total++; if (exception !== got.exc) $display("FAIL op_exc got=%b exp=%b", exception, got.exc); else passed++;
      total++; if (op_div !== got.op_div) $display("FAIL op_done_opdiv got=%b exp=%b", op_div, got.op_div); else passed++;
    end
    tick();
    total++; if (resultRDY !== 1'b0) $display("FAIL op_rdy_pulse got=%b exp=0", resultRDY); else passed++;
    sb.delete();
  endtask

  task automatic test_div_zero();
    exp_t e;
    e.op_div = 1'b1;
    e.exc    = 1'b1;
    div_zero = 1'b1;
    start_op(1'b0, 1'b1);
    sb.push_back(e);
    total++; if (load !== 1'b1) $display("FAIL dz_load got=%b exp=1", load); else passed++;
    total++; if (op_div !== 1'b1) $display("FAIL dz_opdiv got=%b exp=1", op_div); else passed++;
    tick();
    div_zero = 1'b0;
    total++; if (resultRDY !== 1'b1) $display("FAIL dz_rdy got=%b exp=1", resultRDY); else passed++;
    total++; if (step !== 1'b0) $display("FAIL dz_step got=%b exp=0", step); else passed++;
    if (resultRDY === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      total++; if (exception !== got.exc) $display("FAIL dz_exc got=%b exp=%b", exception, got.exc); else passed++;
    end
    tick();
    total++; if (resultRDY !== 1'b0 || busy !== 1'b0) $display("FAIL dz_after rdy=%b busy=%b exp 0 0", resultRDY, busy); else passed++;
    sb.delete();
  endtask

  // MULT aborted by a DIV at count 15; only the DIV may report.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    e.op_div = 1'b0;
    e.exc    = 1'b0;
    start_op(1'b1, 1'b0);
    sb.push_back(e);
    repeat (16) tick();
    total++; if (count !== CW'(15)) $display("FAIL b2b_count15 got=%0d exp=15", count); else passed++;
    start_op(1'b0, 1'b1);
    void'(sb.pop_back());
    e.op_div = 1'b1;
    sb.push_back(e);
    total++; if (load !== 1'b1) $display("FAIL b2b_load got=%b exp=1", load); else passed++;
    total++; if (op_div !== 1'b1) $display("FAIL b2b_opdiv got=%b exp=1", op_div); else passed++;
    total++; if (count !== '0) $display("FAIL b2b_count got=%0d exp=0", count); else passed++;
    cyc = 1;
    while (resultRDY !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== int'(ITERS) + 2) $display("FAIL b2b_latency got=%0d exp=%0d", cyc, ITERS + 2); else passed++;
    if (resultRDY === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      total++; if (op_div !== got.op_div) $display("FAIL b2b_res_opdiv got=%b exp=%b", op_div, got.op_div); else passed++;
      total++; if (exception !== got.exc) $display("FAIL b2b_exc got=%b exp=%b", exception, got.exc); else passed++;
    end
    tick();
    sb.delete();
  endtask

  // Both start lines together are ignored; last latched op was a divide.
  task automatic test_both_start();
    start_op(1'b1, 1'b1);
    total++; if (busy !== 1'b0 || load !== 1'b0) $display("FAIL both_idle busy=%b load=%b exp 0 0", busy, load); else passed++;
    total++; if (op_div !== 1'b1) $display("FAIL both_opdiv got=%b exp=1", op_div); else passed++;
  endtask

  task automatic test_clr_mid();
    int seen;
    start_op(1'b1, 1'b0);
    repeat (21) tick();
    total++; if (count !== CW'(20)) $display("FAIL clr_count20 got=%0d exp=20", count); else passed++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (busy !== 1'b0 || step !== 1'b0 || load !== 1'b0) $display("FAIL clr_idle busy=%b step=%b load=%b exp 0 0 0", busy, step, load); else passed++;
    total++; if (count !== '0) $display("FAIL clr_count got=%0d exp=0", count); else passed++;
    seen = 0;
    repeat (40) begin
      tick();
      if (resultRDY === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL clr_no_rdy got=%0d exp=0", seen); else passed++;
  endtask

`ifdef MULTDIV_EARLY_EXIT_EN
  task automatic test_early_exit();
    start_op(1'b1, 1'b0);
    ovf_in = 1'b1;
    repeat (8) tick();
    total++; if (count !== CW'(7)) $display("FAIL ee_count7 got=%0d exp=7", count); else passed++;
    early_exit = 1'b1;
    tick();
    early_exit = 1'b0;
    ovf_in     = 1'b0;
    total++; if (resultRDY !== 1'b1) $display("FAIL ee_rdy got=%b exp=1", resultRDY); else passed++;
    total++; if (exception !== 1'b1) $display("FAIL ee_exc got=%b exp=1", exception); else passed++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    passed    = 0;
    total     = 0;
    clr       = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    div_zero  = 1'b0;
    ovf_in    = 1'b0;
`ifdef MULTDIV_EARLY_EXIT_EN
    early_exit = 1'b0;
`endif
    test_reset();
    test_full_op(1'b0, -1, 1'b0);
    test_full_op(1'b0, 31, 1'b0);
    test_full_op(1'b0, 10, 1'b0);
    test_full_op(1'b1, -1, 1'b1);
    test_div_zero();
    test_back_to_back();
    test_both_start();
    test_clr_mid();
`ifdef MULTDIV_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
